modred_seq: RTL and testbench

- Parametrised, sequential successor to the combinational remainder stage in the RSA datapath.
- Computes either X mod N for a 2*WIDTH-bit product, or the full modular product (A*B) mod N, using an iterative shift-subtract loop. There are no divider or multiplier arrays.
- Sits between the multiplier/exponentiation controller and the key/data registers, with a start/done handshake.

---
 rtl/rsa_pkg.sv | 13 +
 rtl/modred_step.sv | 33 +++
 rtl/modred_seq.sv | 116 +++++++++++
 tb/tb_modred_seq.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA datapath blocks.
package rsa_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_e;

  localparam logic MODE_REDUCE = 1'b0;
  localparam logic MODE_MULMOD = 1'b1;

endpackage

// File: rtl/modred_step.sv
// One shift-subtract iteration of the modular reduction / modular multiply loop.
module modred_step
  import rsa_pkg::*;
#(
  parameter int unsigned WIDTH = 6
) (
  input  logic [WIDTH:0]   r,
  input  logic [WIDTH-1:0] n,
  input  logic [WIDTH-1:0] a,
  input  logic             b_bit,
  input  logic             mode,
  output logic [WIDTH:0]   r_next
);

  logic [WIDTH:0] n_ext;
  logic [WIDTH:0] dbl;
  logic [WIDTH:0] dbl_red;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] sum_red;
  logic           in_bit;

  always_comb begin
    n_ext  = {1'b0, n};
    in_bit = (mode == MODE_REDUCE) ? b_bit : 1'b0;
    // r < n on entry, so 2r+1 <= 2n-1 fits in WIDTH+1 bits
    dbl     = (r << 1) | {{WIDTH{1'b0}}, in_bit};
    dbl_red = (dbl >= n_ext) ? (dbl - n_ext) : dbl;
    sum     = dbl_red + ((mode == MODE_MULMOD && b_bit) ? {1'b0, a} : '0);
    sum_red = (sum >= n_ext) ? (sum - n_ext) : sum;
    r_next  = (mode == MODE_REDUCE) ? dbl_red : sum_red;
  end

endmodule

// File: rtl/modred_seq.sv
// Sequential X mod N / (A*B) mod N unit: one operand bit per cycle, MSB first.
module modred_seq
  import rsa_pkg::*;
#(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned CNT_W = $clog2(2*WIDTH+1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               mode,
  input  logic [2*WIDTH-1:0] X,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [WIDTH-1:0]   N,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [WIDTH-1:0]   result
);

  localparam logic [CNT_W-1:0] LenRed = CNT_W'(2*WIDTH);
  localparam logic [CNT_W-1:0] LenMul = CNT_W'(WIDTH);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]     r_q, r_d, r_next;
  logic [2*WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0]   a_q, a_d, n_q, n_d, result_q, result_d;
  logic               mode_q, mode_d, err_q, err_d;

  // Operand bits stream out of sh_q's MSB; B is left-aligned so both modes share it
  modred_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .r     (r_q),
    .n     (n_q),
    .a     (a_q),
    .b_bit (sh_q[2*WIDTH-1]),
    .mode  (mode_q),
    .r_next(r_next)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    r_d      = r_q;
    sh_d     = sh_q;
    a_d      = a_q;
    n_d      = n_q;
    mode_d   = mode_q;
    result_d = result_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d = mode;
          a_d    = A;
          n_d    = N;
          sh_d   = (mode == MODE_MULMOD) ? {B, {WIDTH{1'b0}}} : X;
          r_d    = '0;
          if (N == '0 || (mode == MODE_MULMOD && A >= N)) begin
            state_d  = FIN;
            err_d    = 1'b1;
            result_d = '0;
          end else begin
            cnt_d   = (mode == MODE_MULMOD) ? LenMul : LenRed;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        r_d   = r_next;
        sh_d  = sh_q << 1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d  = FIN;
          result_d = r_next[WIDTH-1:0];
          err_d    = 1'b0;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      r_q      <= '0;
      sh_q     <= '0;
      a_q      <= '0;
      n_q      <= '0;
      mode_q   <= 1'b0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      r_q      <= r_d;
      sh_q     <= sh_d;
      a_q      <= a_d;
      n_q      <= n_d;
      mode_q   <= mode_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == FIN);
  assign err    = err_q;
  assign result = result_q;

endmodule

// File: tb/tb_modred_seq.sv
// Directed bench for modred_seq at WIDTH=6 with hand-computed and %-derived expectations.
module tb_modred_seq;

  localparam int unsigned WIDTH = 6;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic               mode;
  logic [2*WIDTH-1:0] X;
  logic [WIDTH-1:0]   A, B, N;
  logic               busy, done, err;
  logic [WIDTH-1:0]   result;

  int errors = 0;
  int checks = 0;
  logic [WIDTH-1:0] last_res;
  logic             last_err;

  always #5 clk = ~clk;

  modred_seq #(
    .WIDTH(WIDTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .mode  (mode),
    .X     (X),
    .A     (A),
    .B     (B),
    .N     (N),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .result(result)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One request; inputs are scrambled right after the start edge, optional
  // extra start pulses are issued mid-run.
  task automatic run_req(input string tag, input logic m, input logic [11:0] x,
                         input logic [5:0] a, input logic [5:0] b, input logic [5:0] n,
                         input logic [5:0] exp_res, input logic exp_err, input bit poke);
    int c;
    int busy_cnt;
    int exp_len;
    exp_len = exp_err ? 0 : (m ? int'(WIDTH) : int'(2*WIDTH));
    @(negedge clk);
    mode = m; X = x; A = a; B = b; N = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mode = ~m; X = ~x; A = ~a; B = ~b; N = ~n;
    c = 0;
    busy_cnt = 0;
    while (!done && c < 40) begin
      if (busy) busy_cnt++;
      if (c == 1 && !exp_err) check({tag, " hold"}, {err, result}, {last_err, last_res});
      start = (poke && (c == 3 || c == 6)) ? 1'b1 : 1'b0;
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    check({tag, " lat"}, 64'(c + 1), 64'(exp_len + 1));
    check({tag, " busy"}, 64'(busy_cnt), 64'(exp_len));
    check({tag, " res"}, result, exp_res);
    check({tag, " err"}, err, exp_err);
    @(negedge clk);
    check({tag, " pulse"}, done, 1'b0);
    last_res = exp_res;
    last_err = exp_err;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, nd, t0, t1;
    rst_n = 1'b0; start = 1'b0; mode = 1'b0;
    X = '0; A = '0; B = '0; N = '0;
    last_res = '0; last_err = 1'b0;
    #1;
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset err", err, 1'b0);
    check("reset result", result, 6'd0);
    #20;
    @(negedge clk) rst_n = 1'b1;

    run_req("red1000", 1'b0, 12'd1000, 6'd0, 6'd0, 6'd37, 6'd1, 1'b0, 1'b0);
    run_req("mul20x33", 1'b1, 12'd0, 6'd20, 6'd33, 6'd61, 6'd50, 1'b0, 1'b0);
    run_req("mul60x63", 1'b1, 12'd0, 6'd60, 6'd63, 6'd61, 6'd59, 1'b0, 1'b0);
    run_req("n0_red", 1'b0, 12'd100, 6'd0, 6'd0, 6'd0, 6'd0, 1'b1, 1'b0);
    run_req("clr_err", 1'b0, 12'd30, 6'd0, 6'd0, 6'd37, 6'd30, 1'b0, 1'b0);
    run_req("n0_mul", 1'b1, 12'd0, 6'd5, 6'd9, 6'd0, 6'd0, 1'b1, 1'b0);
    run_req("a_gt_n", 1'b1, 12'd0, 6'd40, 6'd9, 6'd37, 6'd0, 1'b1, 1'b0);
    run_req("a_eq_n", 1'b1, 12'd0, 6'd37, 6'd9, 6'd37, 6'd0, 1'b1, 1'b0);
    run_req("n1", 1'b0, 12'd4095, 6'd0, 6'd0, 6'd1, 6'd0, 1'b0, 1'b0);
    run_req("red_max", 1'b0, 12'd4095, 6'd0, 6'd0, 6'd62, 6'd3, 1'b0, 1'b0);
    run_req("poke", 1'b0, 12'd2000, 6'd0, 6'd0, 6'd53, 6'd39, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a mode-0 run
    @(negedge clk);
    mode = 1'b0; X = 12'd1000; N = 6'd37; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst busy", busy, 1'b0);
    check("midrst done", done, 1'b0);
    check("midrst err", err, 1'b0);
    check("midrst result", result, 6'd0);
    last_res = '0;
    last_err = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    nd = 0;
    repeat (15) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    check("midrst quiet", 64'(nd), 64'd0);
    run_req("after_rst", 1'b0, 12'd1000, 6'd0, 6'd0, 6'd37, 6'd1, 1'b0, 1'b0);

    // start held high: requests accepted back to back every L+2 cycles
    @(negedge clk);
    mode = 1'b1; A = 6'd20; B = 6'd33; N = 6'd61; start = 1'b1;
    c = 0; nd = 0; t0 = 0; t1 = 0;
    while (nd < 2 && c < 60) begin
      @(negedge clk);
      c++;
      if (done) begin
        if (nd == 0) t0 = c;
        else t1 = c;
        nd++;
        check("b2b res", result, 6'd50);
      end
    end
    start = 1'b0;
    check("b2b count", 64'(nd), 64'd2);
    check("b2b gap", 64'(t1 - t0), 64'(WIDTH + 2));
    repeat (3) @(negedge clk);
    check("b2b idle", {busy, done}, 2'b00);
    last_res = 6'd50;
    last_err = 1'b0;

    // Sweep every legal modulus in both modes against the % model
    for (int n = 1; n < 64; n++) begin
      int xi, ai, bi;
      xi = (n * 67 + 13 * n * n) % 4096;
      ai = (n * 29 + 7) % n;
      bi = (n * 45 + 11) % 64;
      run_req($sformatf("sweep_red n=%0d", n), 1'b0, 12'(xi), 6'd0, 6'd0, 6'(n),
              6'(xi % n), 1'b0, 1'b0);
      run_req($sformatf("sweep_mul n=%0d", n), 1'b1, 12'd0, 6'(ai), 6'(bi), 6'(n),
              6'((ai * bi) % n), 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
